ysyx_23060124_ifu_pf: RTL

YSYX_23060124_IFU_PF -- requirements
Module: ysyx_23060124_ifu_pf

---
 rtl/ysyx_23060124_ifu_pf_if.sv | 27 ++
 rtl/ysyx_23060124_ifu_pf.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_ifu_pf_if.sv
// Bus bundle of the prefetching IFU: memory request/response, redirect and IDU handoff.
// master = IFU side, slave = memory/IDU/control side.
interface ysyx_23060124_ifu_pf_if #(
    parameter int ISA_WIDTH = 32
);
    logic                 o_req_valid;
    logic                 i_req_ready;
    logic [ISA_WIDTH-1:0] o_req_addr;
    logic                 i_rsp_valid;
    logic [ISA_WIDTH-1:0] i_rsp_data;
    logic                 i_redirect_valid;
    logic [ISA_WIDTH-1:0] i_redirect_pc;
    logic                 o_post_valid;
    logic                 i_post_ready;
    logic [ISA_WIDTH-1:0] o_ins;
    logic [ISA_WIDTH-1:0] o_pc;

    modport master (
        output o_req_valid, o_req_addr, o_post_valid, o_ins, o_pc,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_redirect_valid, i_redirect_pc, i_post_ready
    );

    modport slave (
        input  o_req_valid, o_req_addr, o_post_valid, o_ins, o_pc,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_redirect_valid, i_redirect_pc, i_post_ready
    );
endinterface

// File: rtl/ysyx_23060124_ifu_pf.sv
// Prefetching instruction fetch unit: credit-limited in-order requests, PC tag queue, output FIFO.
// Optional performance counters are built when YSYX_23060124_IFU_PERF_EN is defined.
module ysyx_23060124_ifu_pf #(
    parameter int                   ISA_WIDTH = 32,
    parameter int                   PF_DEPTH  = 4,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 'h8000_0000
) (
    input  logic                   clk,
    input  logic                   ifu_rst,
    ysyx_23060124_ifu_pf_if.master bus,
    output logic [31:0]            o_perf_fetch,
    output logic [31:0]            o_perf_stall
);

    localparam int            PW      = $clog2(PF_DEPTH);
    localparam int            CW      = PW + 1;
    localparam int            SW      = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(PF_DEPTH);

    logic [ISA_WIDTH-1:0] fpc_q, fpc_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        drop_q, drop_d;
    logic [CW-1:0]        fcnt_q, fcnt_d;
    logic [PW-1:0]        f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [PW-1:0]        tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;

    logic [ISA_WIDTH-1:0] tag_mem  [PF_DEPTH];
    logic [ISA_WIDTH-1:0] fifo_pc  [PF_DEPTH];
    logic [ISA_WIDTH-1:0] fifo_ins [PF_DEPTH];

    logic          redirect, req_valid, req_fire;
    logic          rsp_drop, rsp_keep, post_valid, pop;
    logic [SW-1:0] credit_used;

    // In-flight plus buffered entries never exceed the FIFO depth, so a kept response always has room.
    assign redirect    = bus.i_redirect_valid;
    assign credit_used = SW'(outst_q) + SW'(fcnt_q);
    assign req_valid   = !ifu_rst && !redirect && (drop_q == '0) && (credit_used < DEPTH_S);
    assign req_fire    = req_valid && bus.i_req_ready;
    assign rsp_drop    = bus.i_rsp_valid && (drop_q != '0);
    assign rsp_keep    = bus.i_rsp_valid && (drop_q == '0) && !redirect;
    assign post_valid  = !ifu_rst && (fcnt_q != '0);
    assign pop         = post_valid && bus.i_post_ready;

    assign bus.o_req_valid  = req_valid;
    assign bus.o_req_addr   = fpc_q;
    assign bus.o_post_valid = post_valid;
    assign bus.o_ins        = post_valid ? fifo_ins[f_rd_q] : '0;
    assign bus.o_pc         = post_valid ? fifo_pc[f_rd_q]  : '0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through this block infers a latch.
        fpc_d   = fpc_q;
        outst_d = outst_q + CW'(req_fire) - CW'(bus.i_rsp_valid);
        drop_d  = drop_q;
        fcnt_d  = fcnt_q + CW'(rsp_keep) - CW'(pop);
        f_wr_d  = f_wr_q + PW'(rsp_keep);
        f_rd_d  = f_rd_q + PW'(pop);
        tq_wr_d = tq_wr_q + PW'(req_fire);
        tq_rd_d = tq_rd_q + PW'(bus.i_rsp_valid);

        if (req_fire) fpc_d  = fpc_q + ISA_WIDTH'(4);
        if (rsp_drop) drop_d = drop_q - CW'(1);

        // Everything still in flight after this edge belongs to the old path and must be discarded.
        if (redirect) begin
            fpc_d  = bus.i_redirect_pc & ~ISA_WIDTH'(3);
            drop_d = outst_d;
            fcnt_d = '0;
            f_wr_d = f_wr_q;
            f_rd_d = f_wr_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (ifu_rst) begin
            fpc_q   <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            fcnt_q  <= '0;
            f_wr_q  <= '0;
            f_rd_q  <= '0;
            tq_wr_q <= '0;
            tq_rd_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            fcnt_q  <= fcnt_d;
            f_wr_q  <= f_wr_d;
            f_rd_q  <= f_rd_d;
            tq_wr_q <= tq_wr_d;
            tq_rd_q <= tq_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; the counts and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tq_wr_q] <= fpc_q;
        if (rsp_keep) begin
            fifo_pc[f_wr_q]  <= tag_mem[tq_rd_q];
            fifo_ins[f_wr_q] <= bus.i_rsp_data;
        end
    end

`ifdef YSYX_23060124_IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (ifu_rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(pop);
            perf_stall_q <= perf_stall_q + 32'(!post_valid);
        end
    end

    assign o_perf_fetch = perf_fetch_q;
    assign o_perf_stall = perf_stall_q;
`else
    assign o_perf_fetch = '0;
    assign o_perf_stall = '0;
`endif

endmodule
